cpu_ctrl_fsm: RTL and testbench

- Controller state machine for the simple RISC datapath.
- Sits directly downstream of the instruction decoder and consumes its opcode[2:0] and op[1:0].
- Drives the decoder's register select (nsel) and all datapath strobes: register-file write, A/B/C/status loads, operand muxes, writeback mux.
- Sequences one instruction per start pulse and raises w when idle.

---
 rtl/ctrl_pkg.sv | 81 ++++++++
 rtl/cpu_ctrl_fsm_if.sv | 36 +++
 rtl/ctrl_out_dec.sv | 59 +++++
 rtl/cpu_ctrl_fsm.sv | 92 +++++++++
 tb/tb_cpu_ctrl_fsm.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the cpu_ctrl_fsm controller slice.
// Optional illegal-instruction trap: CTRL_ILLEGAL_TRAP_EN.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_EXEC      = 3'd5,
        ST_WRITE_REG = 3'd6
`ifdef CTRL_ILLEGAL_TRAP_EN
        , ST_HALT    = 3'd7
`endif
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
`ifdef CTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_out_t;

    // Undefined encodings trap to HALT when the trap is built in, else fall back to WAIT.
    function automatic state_e dispatch(input logic [2:0] opcode, input logic [1:0] op);
        state_e nxt;
        case ({opcode, op})
            {OPC_MOV, OP_MOV_IMM}: nxt = ST_WRITE_IMM;
            {OPC_MOV, OP_MOV_REG}: nxt = ST_GET_B;
            {OPC_ALU, OP_MVN}:     nxt = ST_GET_B;
            {OPC_ALU, OP_ADD}:     nxt = ST_GET_A;
            {OPC_ALU, OP_CMP}:     nxt = ST_GET_A;
            {OPC_ALU, OP_AND}:     nxt = ST_GET_A;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:               nxt = ST_HALT;
`else
            default:               nxt = ST_WAIT;
`endif
        endcase
        return nxt;
    endfunction

    function automatic logic is_cmp(input logic [2:0] opcode, input logic [1:0] op);
        return (opcode == OPC_ALU) && (op == OP_CMP);
    endfunction

    // MOV-reg and MVN pass only the B operand through the ALU, so A is forced to zero.
    function automatic logic zero_a(input logic [2:0] opcode, input logic [1:0] op);
        return ((opcode == OPC_MOV) && (op == OP_MOV_REG)) ||
               ((opcode == OPC_ALU) && (op == OP_MVN));
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Decoder/datapath control bundle; master is the controller, slave is the datapath side.
// Optional illegal flag present only with CTRL_ILLEGAL_TRAP_EN.
interface cpu_ctrl_fsm_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    modport master (
        input  s, opcode, op,
        output w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel
`ifdef CTRL_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output s, opcode, op,
        input  w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel
`ifdef CTRL_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/ctrl_out_dec.sv
// Combinational Moore output decode: controller state (plus held opcode/op in EXEC) to strobes.
// HALT decode present only with CTRL_ILLEGAL_TRAP_EN.
module ctrl_out_dec
    import ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [2:0] opcode_i,
    input  logic [1:0] op_i,
    output ctrl_out_t  out_o
);

    // Per-state strobe decode; everything idles low unless the state claims it.
    always_comb begin
        out_o = '0;
        case (state_i)
            ST_WAIT: begin
                out_o.w = 1'b1;
            end
            ST_DECODE: begin
                out_o.nsel = NSEL_NONE;
            end
            ST_WRITE_IMM: begin
                out_o.nsel  = NSEL_RN;
                out_o.vsel  = VSEL_IMM8;
                out_o.write = 1'b1;
            end
            ST_GET_A: begin
                out_o.nsel  = NSEL_RN;
                out_o.loada = 1'b1;
            end
            ST_GET_B: begin
                out_o.nsel  = NSEL_RM;
                out_o.loadb = 1'b1;
            end
            ST_EXEC: begin
                out_o.asel = zero_a(opcode_i, op_i);
                if (is_cmp(opcode_i, op_i)) begin
                    out_o.loads = 1'b1;
                end else begin
                    out_o.loadc = 1'b1;
                end
            end
            ST_WRITE_REG: begin
                out_o.nsel  = NSEL_RD;
                out_o.vsel  = VSEL_C;
                out_o.write = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_HALT: begin
                out_o.illegal = 1'b1;
            end
`endif
            default: begin
                out_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Instruction sequencer for the simple RISC datapath: one instruction per start pulse.
// Optional trap on undefined encodings: CTRL_ILLEGAL_TRAP_EN.
module cpu_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned DEC_STALL = 0
) (
    input  logic           clk,
    input  logic           reset,
    cpu_ctrl_fsm_if.master bus
);

    localparam logic [1:0] STALL_MAX = 2'(DEC_STALL);

    state_e    state_q, state_d;
    logic [1:0] stall_q, stall_d;
    ctrl_out_t out_s;

    // State and decode-stall counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT;
            stall_q <= 2'd0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // Next-state logic; opcode/op are trusted stable for the whole instruction.
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        case (state_q)
            ST_WAIT: begin
                if (bus.s) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DECODE: begin
                if (stall_q != STALL_MAX) begin
                    stall_d = stall_q + 2'd1;
                end else begin
                    stall_d = 2'd0;
                    state_d = dispatch(bus.opcode, bus.op);
                end
            end
            ST_WRITE_IMM: state_d = ST_WAIT;
            ST_GET_A:     state_d = ST_GET_B;
            ST_GET_B:     state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_cmp(bus.opcode, bus.op)) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: state_d = ST_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_HALT:      state_d = ST_HALT;
`endif
            default: begin
                state_d = ST_WAIT;
                stall_d = 2'd0;
            end
        endcase
    end

    ctrl_out_dec u_out_dec (
        .state_i  (state_q),
        .opcode_i (bus.opcode),
        .op_i     (bus.op),
        .out_o    (out_s)
    );

    assign bus.w     = out_s.w;
    assign bus.nsel  = out_s.nsel;
    assign bus.vsel  = out_s.vsel;
    assign bus.write = out_s.write;
    assign bus.loada = out_s.loada;
    assign bus.loadb = out_s.loadb;
    assign bus.loadc = out_s.loadc;
    assign bus.loads = out_s.loads;
    assign bus.asel  = out_s.asel;
    assign bus.bsel  = out_s.bsel;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal = out_s.illegal;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm at DEC_STALL = 0 and DEC_STALL = 2.
// Covers CTRL_ILLEGAL_TRAP_EN in either build.
module tb_cpu_ctrl_fsm;

    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;

    cpu_ctrl_fsm_if if0 ();
    cpu_ctrl_fsm_if if2 ();

    cpu_ctrl_fsm #(.DEC_STALL(0)) dut0 (.clk(clk), .reset(rst), .bus(if0));
    cpu_ctrl_fsm #(.DEC_STALL(2)) dut2 (.clk(clk), .reset(rst), .bus(if2));

    // Packed view: w | nsel[3] | vsel[2] | write loada loadb loadc loads | asel bsel
    logic [12:0] o0, o2;
    assign o0 = {if0.w, if0.nsel, if0.vsel, if0.write, if0.loada, if0.loadb,
                 if0.loadc, if0.loads, if0.asel, if0.bsel};
    assign o2 = {if2.w, if2.nsel, if2.vsel, if2.write, if2.loada, if2.loadb,
                 if2.loadc, if2.loads, if2.asel, if2.bsel};

    localparam logic [12:0] O_WAIT     = 13'b1_000_00_0_0000_00;
    localparam logic [12:0] O_DEC      = 13'b0_000_00_0_0000_00;
    localparam logic [12:0] O_WIMM     = 13'b0_001_10_1_0000_00;
    localparam logic [12:0] O_GETA     = 13'b0_001_00_0_1000_00;
    localparam logic [12:0] O_GETB     = 13'b0_100_00_0_0100_00;
    localparam logic [12:0] O_EXEC_ALU = 13'b0_000_00_0_0010_00;
    localparam logic [12:0] O_EXEC_Z   = 13'b0_000_00_0_0010_10;
    localparam logic [12:0] O_EXEC_CMP = 13'b0_000_00_0_0001_00;
    localparam logic [12:0] O_WREG     = 13'b0_010_00_1_0000_00;
    localparam logic [12:0] O_HALT     = 13'b0_000_00_0_0000_00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present an instruction on dut0 for one WAIT sample, then drop s.
    task automatic issue0(input logic [2:0] opc, input logic [1:0] op);
        if0.s      = 1'b1;
        if0.opcode = opc;
        if0.op     = op;
        step();
        if0.s = 1'b0;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst = 1'b1;
        if0.s = 1'b0; if0.opcode = 3'b000; if0.op = 2'b00;
        if2.s = 1'b0; if2.opcode = 3'b000; if2.op = 2'b00;
        step();
        step();
        chk("reset_outputs", o0, O_WAIT);
        chk("reset_outputs_stall2", o2, O_WAIT);
        rst = 1'b0;
        step();
        chk("idle_wait", o0, O_WAIT);

        // MOV Rn,#imm8: write for exactly one cycle, w back at edge 3
        issue0(3'b110, 2'b10);
        chk("movi_decode", o0, O_DEC);
        step(); chk("movi_write", o0, O_WIMM);
        step(); chk("movi_done", o0, O_WAIT);

        // ADD, with s pulsed during GET_B which must be ignored
        issue0(3'b101, 2'b00);
        chk("add_decode", o0, O_DEC);
        step(); chk("add_geta", o0, O_GETA);
        step(); chk("add_getb", o0, O_GETB);
        if0.s = 1'b1;
        step(); if0.s = 1'b0;
        chk("add_exec", o0, O_EXEC_ALU);
        step(); chk("add_wreg", o0, O_WREG);
        step(); chk("add_done", o0, O_WAIT);
        step(); chk("add_no_second", o0, O_WAIT);

        // CMP: status load only, no write, 5 edges
        issue0(3'b101, 2'b01);
        step(); chk("cmp_geta", o0, O_GETA);
        step(); chk("cmp_getb", o0, O_GETB);
        step(); chk("cmp_exec", o0, O_EXEC_CMP);
        step(); chk("cmp_done", o0, O_WAIT);

        // MVN: skips GET_A, A forced to zero
        issue0(3'b101, 2'b11);
        step(); chk("mvn_getb", o0, O_GETB);
        step(); chk("mvn_exec", o0, O_EXEC_Z);
        step(); chk("mvn_wreg", o0, O_WREG);
        step(); chk("mvn_done", o0, O_WAIT);

        // MOV Rd,Rm
        issue0(3'b110, 2'b00);
        step(); chk("movr_getb", o0, O_GETB);
        step(); chk("movr_exec", o0, O_EXEC_Z);
        step(); chk("movr_wreg", o0, O_WREG);
        step(); chk("movr_done", o0, O_WAIT);

        // AND reaches EXEC with A taken from the register
        issue0(3'b101, 2'b10);
        step(); chk("and_geta", o0, O_GETA);
        step(); chk("and_getb", o0, O_GETB);
        step(); chk("and_exec", o0, O_EXEC_ALU);
        step(); chk("and_wreg", o0, O_WREG);
        step(); chk("and_done", o0, O_WAIT);

        // DEC_STALL = 2: MOV imm write after edge 4, w after edge 5
        if2.s = 1'b1; if2.opcode = 3'b110; if2.op = 2'b10;
        step(); if2.s = 1'b0;
        chk("stall2_dec0", o2, O_DEC);
        step(); chk("stall2_dec1", o2, O_DEC);
        step(); chk("stall2_dec2", o2, O_DEC);
        step(); chk("stall2_write", o2, O_WIMM);
        step(); chk("stall2_done", o2, O_WAIT);

        // Reset asserted in EXEC of an ADD aborts it immediately
        issue0(3'b101, 2'b00);
        step(); step();
        step(); chk("abort_exec", o0, O_EXEC_ALU);
        rst = 1'b1;
        #1;
        chk("abort_same_cycle", o0, O_WAIT);
        step(); rst = 1'b0;
        step(); chk("abort_after_release", o0, O_WAIT);
        step(); chk("abort_stays_wait", o0, O_WAIT);

        // Undefined encoding 111/00
        issue0(3'b111, 2'b00);
        chk("undef_decode", o0, O_DEC);
`ifdef CTRL_ILLEGAL_TRAP_EN
        step(); chk("halt_outputs", o0, O_HALT);
        chk("halt_illegal", {12'd0, if0.illegal}, 13'd1);
        if0.s = 1'b1;
        step(); if0.s = 1'b0;
        step(); chk("halt_sticky", o0, O_HALT);
        chk("halt_illegal_sticky", {12'd0, if0.illegal}, 13'd1);
        rst = 1'b1;
        #1;
        chk("halt_reset_w", o0, O_WAIT);
        chk("halt_reset_illegal", {12'd0, if0.illegal}, 13'd0);
        step(); rst = 1'b0;
        step(); chk("halt_post_reset", o0, O_WAIT);
`else
        step(); chk("undef_back_to_wait", o0, O_WAIT);
        step(); chk("undef_stays_wait", o0, O_WAIT);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
